vortex_mem_ahb_bridge: RTL

VORTEX_MEM_AHB_BRIDGE -- requirements
Module: vortex_mem_ahb_bridge

---
 rtl/vortex_bridge_pkg.sv | 14 +
 rtl/ahb_if.sv | 26 ++
 rtl/vortex_line_buffer.sv | 29 ++
 rtl/vortex_mem_ahb_bridge.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/vortex_bridge_pkg.sv
// Shared types and AHB-Lite encodings for the Vortex memory to AHB bridge.
package vortex_bridge_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RSP} state_t;

  localparam int unsigned AHB_ADDR_W    = 32;
  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0]  HSIZE_WORD    = 3'b010;
  localparam logic [2:0]  HBURST_SINGLE = 3'b000;

  function automatic int unsigned beats_of(input int unsigned line_w, input int unsigned bus_w);
    return line_w / bus_w;
  endfunction
endpackage

// File: rtl/ahb_if.sv
// AHB-Lite single-manager bundle; the subordinate drives hrdata/hready/hresp.
interface ahb_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    hsel;
  logic [ADDR_WIDTH-1:0]   haddr;
  logic [1:0]              htrans;
  logic                    hwrite;
  logic [2:0]              hsize;
  logic [2:0]              hburst;
  logic [DATA_WIDTH-1:0]   hwdata;
  logic [DATA_WIDTH/8-1:0] hwstrb;
  logic [DATA_WIDTH-1:0]   hrdata;
  logic                    hready;
  logic                    hresp;

  modport manager (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hwstrb,
    input  hrdata, hready, hresp
  );
  modport subordinate (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hwstrb,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/vortex_line_buffer.sv
// Line register: parallel load of a request line, per-word update and per-word readout.
module vortex_line_buffer #(
  parameter  int unsigned LINE_WIDTH = 512,
  parameter  int unsigned WORD_WIDTH = 32,
  localparam int unsigned WORDS      = LINE_WIDTH / WORD_WIDTH,
  localparam int unsigned IDX_W      = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  load,
  input  logic [LINE_WIDTH-1:0] load_line,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [WORD_WIDTH-1:0] wr_word,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [WORD_WIDTH-1:0] rd_word,
  output logic [LINE_WIDTH-1:0] line
);
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)
      line <= '0;
    else if (load)
      line <= load_line;
    else if (wr_en)
      line[wr_idx*WORD_WIDTH +: WORD_WIDTH] <= wr_word;
  end

  assign rd_word = line[rd_idx*WORD_WIDTH +: WORD_WIDTH];
endmodule

// File: rtl/vortex_mem_ahb_bridge.sv
// Splits one Vortex memory line request into single-word AHB-Lite transfers, one request at a time.
module vortex_mem_ahb_bridge
  import vortex_bridge_pkg::*;
#(
  parameter int unsigned LINE_WIDTH      = 512,
  parameter int unsigned LINE_ADDR_WIDTH = 26,
  parameter int unsigned TAG_WIDTH       = 56,
  parameter int unsigned BUS_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic                       mem_req_valid,
  input  logic                       mem_req_rw,
  input  logic [LINE_WIDTH/8-1:0]    mem_req_byteen,
  input  logic [LINE_ADDR_WIDTH-1:0] mem_req_addr,
  input  logic [LINE_WIDTH-1:0]      mem_req_data,
  input  logic [TAG_WIDTH-1:0]       mem_req_tag,
  output logic                       mem_req_ready,
  output logic                       mem_rsp_valid,
  output logic [LINE_WIDTH-1:0]      mem_rsp_data,
  output logic [TAG_WIDTH-1:0]       mem_rsp_tag,
  input  logic                       mem_rsp_ready,
  ahb_if.manager                     ahb,
  output logic                       bus_error
);
  localparam int unsigned BEATS   = beats_of(LINE_WIDTH, BUS_WIDTH);
  localparam int unsigned IDX_W   = $clog2(BEATS);
  localparam int unsigned STRB_W  = BUS_WIDTH / 8;
  localparam int unsigned OFS_W   = $clog2(LINE_WIDTH / 8);
  localparam int unsigned WORD_SH = $clog2(STRB_W);

  state_t                      state;
  logic [IDX_W-1:0]            beat;
  logic                        rw;
  logic [LINE_ADDR_WIDTH-1:0]  addr;
  logic [LINE_WIDTH/8-1:0]     byteen;
  logic [TAG_WIDTH-1:0]        tag;
  logic [BUS_WIDTH-1:0]        buf_rd_word;

  logic [LINE_WIDTH/8-1:0]     scan_en;
  logic                        scan_rw;
  logic [IDX_W:0]              scan_from;
  logic [LINE_ADDR_WIDTH-1:0]  scan_addr;
  logic                        nxt_found;
  logic [IDX_W-1:0]            nxt_beat;
  logic [AHB_ADDR_W-1:0]       nxt_haddr;

  // Next beat to issue: reads take every beat, writes skip beats whose strobe slice is empty.
  // In IDLE the scan looks at the incoming request so the first transfer is chosen on acceptance.
  always_comb begin
    scan_en   = (state == IDLE) ? mem_req_byteen : byteen;
    scan_rw   = (state == IDLE) ? mem_req_rw : rw;
    scan_addr = (state == IDLE) ? mem_req_addr : addr;
    scan_from = (state == IDLE) ? '0 : {1'b0, beat} + (IDX_W+1)'(1);
    nxt_found = 1'b0;
    nxt_beat  = '0;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (!nxt_found && (IDX_W+1)'(i) >= scan_from &&
          (!scan_rw || |scan_en[i*STRB_W +: STRB_W])) begin
        nxt_found = 1'b1;
        nxt_beat  = IDX_W'(i);
      end
    end
    nxt_haddr = AHB_ADDR_W'({scan_addr, {OFS_W{1'b0}}}) + (AHB_ADDR_W'(nxt_beat) << WORD_SH);
  end

  vortex_line_buffer #(
    .LINE_WIDTH (LINE_WIDTH),
    .WORD_WIDTH (BUS_WIDTH)
  ) u_line (
    .clk       (clk),
    .nRST      (nRST),
    .load      (state == IDLE && mem_req_valid),
    .load_line (mem_req_data),
    .wr_en     (state == DATA && ahb.hready && !rw),
    .wr_idx    (beat),
    .wr_word   (ahb.hrdata),
    .rd_idx    (beat),
    .rd_word   (buf_rd_word),
    .line      (mem_rsp_data)
  );

  assign mem_rsp_tag = tag;
  assign ahb.hsize   = HSIZE_WORD;
  assign ahb.hburst  = HBURST_SINGLE;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state         <= IDLE;
      beat          <= '0;
      rw            <= 1'b0;
      addr          <= '0;
      byteen        <= '0;
      tag           <= '0;
      mem_req_ready <= 1'b1;
      mem_rsp_valid <= 1'b0;
      bus_error     <= 1'b0;
      ahb.htrans    <= HTRANS_IDLE;
      ahb.hsel      <= 1'b0;
      ahb.haddr     <= '0;
      ahb.hwrite    <= 1'b0;
      ahb.hwdata    <= '0;
      ahb.hwstrb    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req_valid) begin
            rw     <= mem_req_rw;
            addr   <= mem_req_addr;
            byteen <= mem_req_byteen;
            tag    <= mem_req_tag;
            beat   <= nxt_beat;
            if (nxt_found) begin
              state         <= ADDR;
              mem_req_ready <= 1'b0;
              ahb.htrans    <= HTRANS_NONSEQ;
              ahb.hsel      <= 1'b1;
              ahb.haddr     <= nxt_haddr;
              ahb.hwrite    <= mem_req_rw;
            end
          end
        end
        ADDR: begin
          if (ahb.hready) begin
            state      <= DATA;
            ahb.htrans <= HTRANS_IDLE;
            ahb.hsel   <= 1'b0;
            ahb.hwdata <= buf_rd_word;
            ahb.hwstrb <= rw ? byteen[beat*STRB_W +: STRB_W] : '0;
          end
        end
        DATA: begin
          if (ahb.hresp)
            bus_error <= 1'b1;
          if (ahb.hready) begin
            if (nxt_found) begin
              beat       <= nxt_beat;
              state      <= ADDR;
              ahb.htrans <= HTRANS_NONSEQ;
              ahb.hsel   <= 1'b1;
              ahb.haddr  <= nxt_haddr;
            end else if (!rw) begin
              state         <= RSP;
              mem_rsp_valid <= 1'b1;
            end else begin
              state         <= IDLE;
              mem_req_ready <= 1'b1;
            end
          end
        end
        RSP: begin
          if (mem_rsp_ready) begin
            state         <= IDLE;
            mem_rsp_valid <= 1'b0;
            mem_req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
